// File: rtl/cl2_pl_exu_pkg.sv
// Shared EXU pipeline types: architectural widths and write-back requester indices.
`include "cl2_arch_desc.svh"

package cl2_pl_exu_pkg;

  localparam int CL2_XLEN          = `CL2_XLEN;
  localparam int CL2_REGFILE_WIDTH = `CL2_REGFILE_WIDTH;
  localparam int CL2_REGFILE_NUM   = `CL2_REGFILE_NUM;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_req_e;

  localparam int WB_REQ_NUM = 3;

endpackage

// File: rtl/cl2_arch_desc.svh
// Architectural sizing shared by the CL2 core: data width and register file geometry.
`ifndef CL2_ARCH_DESC_SVH
`define CL2_ARCH_DESC_SVH

`define CL2_XLEN           32
`define CL2_REGFILE_WIDTH  5
`define CL2_REGFILE_NUM    32

`endif

// File: rtl/cl2_pl_exu_wb_arb.sv
// Single-grant write-back arbiter: LSU > MDU > ALU, with ALU promotion after a
// run of STARVE_LIM denied cycles so the ALU cannot be locked out forever.
module cl2_pl_exu_wb_arb
  import cl2_pl_exu_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [WB_REQ_NUM-1:0] req_i,
  output logic [WB_REQ_NUM-1:0] gnt_o
);

  logic [2:0] starve_cnt_q;
  logic [2:0] starve_cnt_d;
  logic       alu_starved;

  always_comb begin
    gnt_o       = '0;
    alu_starved = req_i[WB_ALU] && (starve_cnt_q == 3'(STARVE_LIM));
    if (!rst_n_i) begin
      gnt_o = '0;
    end else if (alu_starved) begin
      gnt_o[WB_ALU] = 1'b1;
    end else if (req_i[WB_LSU]) begin
      gnt_o[WB_LSU] = 1'b1;
    end else if (req_i[WB_MDU]) begin
      gnt_o[WB_MDU] = 1'b1;
    end else if (req_i[WB_ALU]) begin
      gnt_o[WB_ALU] = 1'b1;
    end
  end

  // Counts only an unbroken run of denied ALU requests; saturates at 7.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req_i[WB_ALU] || gnt_o[WB_ALU]) begin
      starve_cnt_d = 3'd0;
    end else if (starve_cnt_q != 3'd7) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      starve_cnt_q <= 3'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/cl2_pl_exu_rf_sched.sv
// EXU register-file scheduler: pending-write scoreboard gating issue, plus the
// arbitrated single regfile write port shared by ALU, LSU and MDU.
module cl2_pl_exu_rf_sched
  import cl2_pl_exu_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         iss_vld_i,
  input  logic                         iss_rs1_en_i,
  input  logic [CL2_REGFILE_WIDTH-1:0] iss_rs1_idx_i,
  input  logic                         iss_rs2_en_i,
  input  logic [CL2_REGFILE_WIDTH-1:0] iss_rs2_idx_i,
  input  logic                         iss_rd_en_i,
  input  logic [CL2_REGFILE_WIDTH-1:0] iss_rd_idx_i,
  input  logic                         iss_long_i,
  output logic                         iss_rdy_o,
  input  logic                         alu_wb_vld_i,
  input  logic [CL2_REGFILE_WIDTH-1:0] alu_wb_idx_i,
  input  logic [CL2_XLEN-1:0]          alu_wb_dat_i,
  output logic                         alu_wb_rdy_o,
  input  logic                         lsu_wb_vld_i,
  input  logic [CL2_REGFILE_WIDTH-1:0] lsu_wb_idx_i,
  input  logic [CL2_XLEN-1:0]          lsu_wb_dat_i,
  output logic                         lsu_wb_rdy_o,
  input  logic                         mdu_wb_vld_i,
  input  logic [CL2_REGFILE_WIDTH-1:0] mdu_wb_idx_i,
  input  logic [CL2_XLEN-1:0]          mdu_wb_dat_i,
  output logic                         mdu_wb_rdy_o,
  output logic                         rf_wen_o,
  output logic [CL2_REGFILE_WIDTH-1:0] rf_widx_o,
  output logic [CL2_XLEN-1:0]          rf_wdat_o,
  output logic                         sb_busy_o
);

  logic [CL2_REGFILE_NUM-1:0]   pend_q;
  logic [CL2_REGFILE_NUM-1:0]   pend_d;
  logic [CL2_REGFILE_NUM-1:0]   set_mask;
  logic [CL2_REGFILE_NUM-1:0]   clr_mask;
  logic                         hazard;
  logic                         iss_fire;
  logic [WB_REQ_NUM-1:0]        wb_req;
  logic [WB_REQ_NUM-1:0]        wb_gnt;
  logic [CL2_REGFILE_WIDTH-1:0] wb_idx;
  logic [CL2_XLEN-1:0]          wb_dat;

  // No bypass: a write-back clearing a pending bit only unblocks issue next cycle.
  always_comb begin
    hazard    = (iss_rs1_en_i && (iss_rs1_idx_i != '0) && pend_q[iss_rs1_idx_i]) ||
                (iss_rs2_en_i && (iss_rs2_idx_i != '0) && pend_q[iss_rs2_idx_i]) ||
                (iss_rd_en_i  && (iss_rd_idx_i  != '0) && pend_q[iss_rd_idx_i]);
    iss_rdy_o = rst_n_i && !hazard;
    iss_fire  = iss_vld_i && iss_rdy_o;
    sb_busy_o = rst_n_i && (|pend_q);
  end

  always_comb begin
    wb_req         = '0;
    wb_req[WB_ALU] = alu_wb_vld_i;
    wb_req[WB_LSU] = lsu_wb_vld_i;
    wb_req[WB_MDU] = mdu_wb_vld_i;
  end

  cl2_pl_exu_wb_arb #(
    .STARVE_LIM (STARVE_LIM)
  ) u_wb_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req_i   (wb_req),
    .gnt_o   (wb_gnt)
  );

  always_comb begin
    wb_idx = '0;
    wb_dat = '0;
    if (wb_gnt[WB_LSU]) begin
      wb_idx = lsu_wb_idx_i;
      wb_dat = lsu_wb_dat_i;
    end else if (wb_gnt[WB_MDU]) begin
      wb_idx = mdu_wb_idx_i;
      wb_dat = mdu_wb_dat_i;
    end else if (wb_gnt[WB_ALU]) begin
      wb_idx = alu_wb_idx_i;
      wb_dat = alu_wb_dat_i;
    end
    alu_wb_rdy_o = wb_gnt[WB_ALU];
    lsu_wb_rdy_o = wb_gnt[WB_LSU];
    mdu_wb_rdy_o = wb_gnt[WB_MDU];
    rf_wen_o     = (|wb_gnt) && (wb_idx != '0);
    rf_widx_o    = wb_idx;
    rf_wdat_o    = wb_dat;
  end

  // Set is applied after clear so a same-cycle set of the same index wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_fire && iss_long_i && iss_rd_en_i) begin
      set_mask[iss_rd_idx_i] = 1'b1;
    end
    if (wb_gnt[WB_LSU] || wb_gnt[WB_MDU]) begin
      clr_mask[wb_idx] = 1'b1;
    end
    pend_d    = (pend_q & ~clr_mask) | set_mask;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_cl2_pl_exu_rf_sched.sv
// Directed self-checking bench for cl2_pl_exu_rf_sched: hazards, arbitration,
// starvation promotion, x0 handling and reset in the middle of activity.
module tb_cl2_pl_exu_rf_sched;
  import cl2_pl_exu_pkg::*;

  localparam int STARVE_LIM = 4;

  logic                         clk;
  logic                         rst_n;
  logic                         iss_vld, iss_rs1_en, iss_rs2_en, iss_rd_en, iss_long;
  logic [CL2_REGFILE_WIDTH-1:0] iss_rs1_idx, iss_rs2_idx, iss_rd_idx;
  logic                         iss_rdy;
  logic                         alu_vld, lsu_vld, mdu_vld;
  logic [CL2_REGFILE_WIDTH-1:0] alu_idx, lsu_idx, mdu_idx;
  logic [CL2_XLEN-1:0]          alu_dat, lsu_dat, mdu_dat;
  logic                         alu_rdy, lsu_rdy, mdu_rdy;
  logic                         rf_wen;
  logic [CL2_REGFILE_WIDTH-1:0] rf_widx;
  logic [CL2_XLEN-1:0]          rf_wdat;
  logic                         sb_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  cl2_pl_exu_rf_sched #(.STARVE_LIM(STARVE_LIM)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .iss_vld_i(iss_vld),
    .iss_rs1_en_i(iss_rs1_en), .iss_rs1_idx_i(iss_rs1_idx),
    .iss_rs2_en_i(iss_rs2_en), .iss_rs2_idx_i(iss_rs2_idx),
    .iss_rd_en_i(iss_rd_en), .iss_rd_idx_i(iss_rd_idx),
    .iss_long_i(iss_long), .iss_rdy_o(iss_rdy),
    .alu_wb_vld_i(alu_vld), .alu_wb_idx_i(alu_idx), .alu_wb_dat_i(alu_dat), .alu_wb_rdy_o(alu_rdy),
    .lsu_wb_vld_i(lsu_vld), .lsu_wb_idx_i(lsu_idx), .lsu_wb_dat_i(lsu_dat), .lsu_wb_rdy_o(lsu_rdy),
    .mdu_wb_vld_i(mdu_vld), .mdu_wb_idx_i(mdu_idx), .mdu_wb_dat_i(mdu_dat), .mdu_wb_rdy_o(mdu_rdy),
    .rf_wen_o(rf_wen), .rf_widx_o(rf_widx), .rf_wdat_o(rf_wdat),
    .sb_busy_o(sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge and are checked 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    iss_vld = 0; iss_rs1_en = 0; iss_rs2_en = 0; iss_rd_en = 0; iss_long = 0;
    iss_rs1_idx = '0; iss_rs2_idx = '0; iss_rd_idx = '0;
    alu_vld = 0; lsu_vld = 0; mdu_vld = 0;
    alu_idx = '0; lsu_idx = '0; mdu_idx = '0;
    alu_dat = '0; lsu_dat = '0; mdu_dat = '0;
  endtask

  task automatic drive_issue(input logic rs1_en, input int rs1, input logic rs2_en, input int rs2,
                             input logic rd_en, input int rd, input logic lng);
    iss_vld = 1; iss_rs1_en = rs1_en; iss_rs2_en = rs2_en; iss_rd_en = rd_en; iss_long = lng;
    iss_rs1_idx = CL2_REGFILE_WIDTH'(rs1);
    iss_rs2_idx = CL2_REGFILE_WIDTH'(rs2);
    iss_rd_idx  = CL2_REGFILE_WIDTH'(rd);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    drive_issue(1, 4, 1, 6, 1, 8, 1);
    alu_vld = 1; alu_idx = 5'd1; alu_dat = 32'h11;
    lsu_vld = 1; lsu_idx = 5'd2; lsu_dat = 32'h22;
    mdu_vld = 1; mdu_idx = 5'd3; mdu_dat = 32'h33;
    settle();
    tests_run++; if (iss_rdy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_iss_rdy got %b want 0", iss_rdy); end
    tests_run++; if ({alu_rdy, lsu_rdy, mdu_rdy} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_wb_rdy got %b want 000", {alu_rdy, lsu_rdy, mdu_rdy}); end
    tests_run++; if (rf_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rf_wen got %b want 0", rf_wen); end
    tests_run++; if (rf_widx !== 5'd0 || rf_wdat !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_rf_bus got %0d/%h want 0/0", rf_widx, rf_wdat); end
    tests_run++; if (sb_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sb_busy got %b want 0", sb_busy); end
    step();
    step();
    clear_inputs();
    rst_n = 1;
    settle();
    tests_run++; if (sb_busy !== 1'b0 || iss_rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset got busy=%b rdy=%b want busy=0 rdy=1", sb_busy, iss_rdy); end
    step();
  endtask

  task automatic test_long_load_hazard();
    clear_inputs();
    drive_issue(0, 0, 0, 0, 1, 5, 1);
    settle();
    tests_run++; if (iss_rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_issue_rdy got %b want 1", iss_rdy); end
    step();
    clear_inputs();
    drive_issue(1, 5, 0, 0, 0, 0, 0);
    lsu_vld = 1; lsu_idx = 5'd5; lsu_dat = 32'hDEADBEEF;
    settle();
    tests_run++; if (iss_rdy !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_use_stall got %b want 0", iss_rdy); end
    tests_run++; if (sb_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_sb_busy got %b want 1", sb_busy); end
    tests_run++; if (lsu_rdy !== 1'b1 || rf_wen !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_wb_write got rdy=%b wen=%b want 1/1", lsu_rdy, rf_wen); end
    tests_run++; if (rf_widx !== 5'd5 || rf_wdat !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL load_wb_bus got %0d/%h want 5/deadbeef", rf_widx, rf_wdat); end
    step();
    lsu_vld = 0;
    settle();
    tests_run++; if (iss_rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_use_release got %b want 1", iss_rdy); end
    tests_run++; if (sb_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_sb_clear got %b want 0", sb_busy); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_priority();
    clear_inputs();
    alu_vld = 1; alu_idx = 5'd1; alu_dat = 32'hA1;
    lsu_vld = 1; lsu_idx = 5'd2; lsu_dat = 32'hB2;
    mdu_vld = 1; mdu_idx = 5'd3; mdu_dat = 32'hC3;
    settle();
    tests_run++; if ({alu_rdy, lsu_rdy, mdu_rdy} !== 3'b010 || rf_widx !== 5'd2 || rf_wdat !== 32'hB2) begin tests_failed++; $display("[TB] FAIL prio_lsu got a/l/m=%b idx=%0d dat=%h want 010 2 b2", {alu_rdy, lsu_rdy, mdu_rdy}, rf_widx, rf_wdat); end
    step();
    lsu_vld = 0;
    settle();
    tests_run++; if ({alu_rdy, lsu_rdy, mdu_rdy} !== 3'b001 || rf_widx !== 5'd3 || rf_wdat !== 32'hC3) begin tests_failed++; $display("[TB] FAIL prio_mdu got a/l/m=%b idx=%0d dat=%h want 001 3 c3", {alu_rdy, lsu_rdy, mdu_rdy}, rf_widx, rf_wdat); end
    step();
    mdu_vld = 0;
    settle();
    tests_run++; if ({alu_rdy, lsu_rdy, mdu_rdy} !== 3'b100 || rf_widx !== 5'd1 || rf_wdat !== 32'hA1) begin tests_failed++; $display("[TB] FAIL prio_alu got a/l/m=%b idx=%0d dat=%h want 100 1 a1", {alu_rdy, lsu_rdy, mdu_rdy}, rf_widx, rf_wdat); end
    step();
    clear_inputs();
    settle();
    tests_run++; if (rf_wen !== 1'b0 || rf_widx !== 5'd0 || rf_wdat !== 32'd0) begin tests_failed++; $display("[TB] FAIL idle_bus got wen=%b idx=%0d dat=%h want 0 0 0", rf_wen, rf_widx, rf_wdat); end
    step();
  endtask

  task automatic test_starvation();
    clear_inputs();
    alu_vld = 1; alu_idx = 5'd10; alu_dat = 32'h10;
    lsu_vld = 1; lsu_idx = 5'd11; lsu_dat = 32'h11;
    mdu_vld = 1; mdu_idx = 5'd12; mdu_dat = 32'h12;
    for (int c = 1; c <= STARVE_LIM + 2; c++) begin
      logic exp_alu;
      exp_alu = (c == STARVE_LIM + 1);
      settle();
      tests_run++; if (alu_rdy !== exp_alu || lsu_rdy !== !exp_alu) begin tests_failed++; $display("[TB] FAIL starve_cycle%0d got alu=%b lsu=%b want alu=%b lsu=%b", c, alu_rdy, lsu_rdy, exp_alu, !exp_alu); end
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_x0();
    clear_inputs();
    alu_vld = 1; alu_idx = 5'd0; alu_dat = 32'h1234;
    settle();
    tests_run++; if (alu_rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL x0_alu_rdy got %b want 1", alu_rdy); end
    tests_run++; if (rf_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL x0_rf_wen got %b want 0", rf_wen); end
    step();
    clear_inputs();
    drive_issue(0, 0, 0, 0, 1, 0, 1);
    settle();
    tests_run++; if (iss_rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL x0_issue_rdy got %b want 1", iss_rdy); end
    step();
    clear_inputs();
    drive_issue(1, 0, 1, 0, 1, 0, 0);
    settle();
    tests_run++; if (sb_busy !== 1'b0 || iss_rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL x0_scoreboard got busy=%b rdy=%b want 0/1", sb_busy, iss_rdy); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_waw();
    clear_inputs();
    drive_issue(0, 0, 0, 0, 1, 7, 1);
    step();
    clear_inputs();
    drive_issue(1, 1, 1, 2, 1, 7, 0);
    for (int c = 0; c < 3; c++) begin
      settle();
      tests_run++; if (iss_rdy !== 1'b0) begin tests_failed++; $display("[TB] FAIL waw_stall%0d got %b want 0", c, iss_rdy); end
      step();
    end
    mdu_vld = 1; mdu_idx = 5'd7; mdu_dat = 32'h77;
    settle();
    tests_run++; if (mdu_rdy !== 1'b1 || iss_rdy !== 1'b0 || rf_wen !== 1'b1) begin tests_failed++; $display("[TB] FAIL waw_mdu_wb got mdu_rdy=%b iss_rdy=%b wen=%b want 1/0/1", mdu_rdy, iss_rdy, rf_wen); end
    step();
    mdu_vld = 0;
    settle();
    tests_run++; if (iss_rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL waw_release got %b want 1", iss_rdy); end
    step();
    clear_inputs();
    settle();
    tests_run++; if (sb_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL waw_alu_no_set got %b want 0", sb_busy); end
    step();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    drive_issue(0, 0, 0, 0, 1, 3, 1);
    step();
    drive_issue(0, 0, 0, 0, 1, 9, 1);
    step();
    clear_inputs();
    drive_issue(1, 9, 0, 0, 0, 0, 0);
    settle();
    tests_run++; if (sb_busy !== 1'b1 || iss_rdy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_pending got busy=%b rdy=%b want 1/0", sb_busy, iss_rdy); end
    step();
    rst_n = 0;
    lsu_vld = 1; lsu_idx = 5'd3; lsu_dat = 32'h33;
    alu_vld = 1; alu_idx = 5'd4; alu_dat = 32'h44;
    settle();
    tests_run++; if ({iss_rdy, alu_rdy, lsu_rdy, mdu_rdy, rf_wen, sb_busy} !== 6'b0 || rf_widx !== 5'd0 || rf_wdat !== 32'd0) begin tests_failed++; $display("[TB] FAIL mid_reset_outputs got rdy/a/l/m/wen/busy=%b idx=%0d dat=%h want all 0", {iss_rdy, alu_rdy, lsu_rdy, mdu_rdy, rf_wen, sb_busy}, rf_widx, rf_wdat); end
    step();
    rst_n = 1;
    clear_inputs();
    drive_issue(1, 3, 1, 9, 0, 0, 0);
    settle();
    tests_run++; if (sb_busy !== 1'b0 || iss_rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_after_reset got busy=%b rdy=%b want 0/1", sb_busy, iss_rdy); end
    step();
    clear_inputs();
    lsu_vld = 1; lsu_idx = 5'd3; lsu_dat = 32'hCAFE0003;
    settle();
    tests_run++; if (lsu_rdy !== 1'b1 || rf_wen !== 1'b1 || rf_wdat !== 32'hCAFE0003) begin tests_failed++; $display("[TB] FAIL stale_wb got rdy=%b wen=%b dat=%h want 1/1/cafe0003", lsu_rdy, rf_wen, rf_wdat); end
    step();
    clear_inputs();
    settle();
    tests_run++; if (sb_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL stale_wb_busy got %b want 0", sb_busy); end
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clear_inputs();
    rst_n = 0;
    #1;
    test_reset();
    test_long_load_hazard();
    test_priority();
    test_starvation();
    test_x0();
    test_waw();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cl2_pl_exu_rf_sched.md
CL2_PL_EXU_RF_SCHED -- requirements
Module: cl2_pl_exu_rf_sched

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 4, meaning consecutive denied ALU-request cycles before the ALU is promoted to top priority (range 1..7).
REQ-002 SHALL have clk_i input 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n_i input 1: reset, synchronous, active-low.
REQ-004 SHALL have iss_vld_i input 1: an instruction is presented at issue.
REQ-005 SHALL have iss_rs1_en_i / iss_rs2_en_i input 1 each, and iss_rs1_idx_i / iss_rs2_idx_i input CL2_REGFILE_WIDTH each: the source operands used.
REQ-006 SHALL have iss_rd_en_i input 1 and iss_rd_idx_i input CL2_REGFILE_WIDTH: the destination.
REQ-007 SHALL have iss_long_i input 1: the instruction writes back through the LSU or MDU.
REQ-008 SHALL have iss_rdy_o output 1: the instruction is hazard-free and may issue.
REQ-009 SHALL have, for each of alu/lsu/mdu: <p>_wb_vld_i input 1, <p>_wb_idx_i input CL2_REGFILE_WIDTH, <p>_wb_dat_i input CL2_XLEN, <p>_wb_rdy_o output 1.
REQ-010 SHALL have rf_wen_o output 1, rf_widx_o output CL2_REGFILE_WIDTH, rf_wdat_o output CL2_XLEN: the regfile write port.
REQ-011 SHALL have sb_busy_o output 1: at least one long-latency write is outstanding.

Function
REQ-012 SHALL keep a CL2_REGFILE_NUM-bit pending scoreboard; bit 0 SHALL be constant 0.
REQ-013 SHALL drive iss_rdy_o = 0 if any enabled, nonzero rs1/rs2/rd index has its pending bit set, else 1; the value is combinational from the current scoreboard, with no bypass of a same-cycle clear.
REQ-014 SHALL treat issue as fired when iss_vld_i & iss_rdy_o; if fired with iss_long_i & iss_rd_en_i & rd != 0, SHALL set pending[rd] at the next edge.
REQ-015 SHALL grant at most one write-back requester per cycle; <p>_wb_rdy_o is combinational, and a transfer occurs on vld & rdy.
REQ-016 SHALL use default priority LSU > MDU > ALU.
REQ-017 SHALL count consecutive cycles in which alu_wb_vld_i=1 and alu_wb_rdy_o=0, with a saturating 3-bit counter; the counter SHALL clear on ALU grant or alu_wb_vld_i=0.
REQ-018 SHALL, when the counter equals STARVE_LIM, give the ALU top priority for that cycle.
REQ-019 SHALL drive rf_widx_o/rf_wdat_o from the granted requester in the same cycle, and rf_wen_o = grant & (idx != 0).
REQ-020 SHALL accept (rdy=1) a granted write to x0 but SHALL NOT assert rf_wen_o for it.
REQ-021 SHALL hold rf_widx_o/rf_wdat_o at 0 when no requester is granted.
REQ-022 SHALL clear pending[idx] at the next edge on an LSU or MDU transfer; ALU transfers SHALL NOT alter the scoreboard.
REQ-023 SHALL let set win over clear when the same index is set and cleared in one cycle.
REQ-024 SHALL NOT gate, check or flag a long write-back to a non-pending index; it is written normally.
REQ-025 SHALL drive sb_busy_o = OR of all pending bits (registered state, no same-cycle lookahead).

Reset
REQ-026 SHALL, while rst_n_i=0 at a clock edge, clear the scoreboard and starvation counter.
REQ-027 SHALL, while rst_n_i=0, force iss_rdy_o, all <p>_wb_rdy_o, rf_wen_o, rf_widx_o, rf_wdat_o and sb_busy_o to 0.
REQ-028 SHALL discard in-flight long writes on reset mid-operation; a later write-back for them is treated per REQ-024.

Structure
REQ-029 SHALL take CL2_XLEN, CL2_REGFILE_WIDTH and CL2_REGFILE_NUM from cl2_arch_desc.svh.
REQ-030 SHALL place the requester-index enum (ALU=0, LSU=1, MDU=2) and the requester count in shared package cl2_pl_exu_pkg.
REQ-031 SHALL implement the priority/starvation logic in sub-module cl2_pl_exu_wb_arb; scoreboard and hazard logic stay in the top.

Verification
REQ-032 SHALL cover long-load hazard: issue long rd=5, then rs1=5 -> iss_rdy_o=0; LSU wb idx=5 dat=0xDEADBEEF -> rf_wen_o=1 that cycle, and iss_rdy_o=1 on the next cycle.
REQ-033 SHALL cover priority: ALU, LSU and MDU all valid with idx 1/2/3 -> grant LSU, then MDU, then ALU on successive cycles.
REQ-034 SHALL cover starvation: LSU and MDU held valid continuously, ALU valid -> ALU granted on the (STARVE_LIM+1)th cycle, i.e. cycle 5 at default.
REQ-035 SHALL cover x0: ALU wb idx=0 dat=0x1234 -> alu_wb_rdy_o=1 and rf_wen_o=0; issue long rd=0 -> scoreboard unchanged and sb_busy_o=0.
REQ-036 SHALL cover WAW stall: pending[7] set, issue ALU op rd=7 -> iss_rdy_o=0 until the MDU wb of idx 7 completes.
REQ-037 SHALL cover reset mid-operation: pending[3,9] set, rst_n_i low for one edge -> sb_busy_o=0 and all outputs 0 during reset.
